// File: rtl/rca_pipe.sv
// rtl/rca_pipe.sv - pipelined ripple-carry adder/subtractor with valid/ready stream handshake
module rca_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int CW = WIDTH / STAGES;
    localparam int L  = STAGES - 1;
    localparam logic [WIDTH-1:0] SLICE_ONES = WIDTH'({CW{1'b1}});

    function automatic logic [CW:0] ripple(input logic [CW-1:0] a,
                                           input logic [CW-1:0] b,
                                           input logic          ci);
        logic          c;
        logic [CW-1:0] s;
        c = ci;
        s = '0;
        for (int i = 0; i < CW; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        return {c, s};
    endfunction

    // Each stage keeps full-width operand (skew) and sum (deskew) vectors;
    // only slice k of the sum is written by stage k.
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  bx_q  [STAGES];
    logic [WIDTH-1:0]  s_q   [STAGES];
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;

    logic [WIDTH-1:0]  a_src  [STAGES];
    logic [WIDTH-1:0]  bx_src [STAGES];
    logic [WIDTH-1:0]  s_src  [STAGES];
    logic [WIDTH-1:0]  s_nxt  [STAGES];
    logic [STAGES-1:0] c_src;
    logic [STAGES-1:0] c_nxt;
    logic [STAGES-1:0] v_src;
    logic              adv;

    assign out_valid = v_q[L];
    assign adv       = !out_valid | out_ready;
    assign in_ready  = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] MASK = SLICE_ONES << (k * CW);
        logic [CW:0] r;

        if (k == 0) begin : g_first
            assign a_src[k]  = A;
            assign bx_src[k] = sub ? ~B : B;
            assign c_src[k]  = sub | cin;
            assign v_src[k]  = in_valid;
            assign s_src[k]  = '0;
        end else begin : g_rest
            assign a_src[k]  = a_q[k-1];
            assign bx_src[k] = bx_q[k-1];
            assign c_src[k]  = c_q[k-1];
            assign v_src[k]  = v_q[k-1];
            assign s_src[k]  = s_q[k-1];
        end

        assign r        = ripple(a_src[k][k*CW +: CW], bx_src[k][k*CW +: CW], c_src[k]);
        assign c_nxt[k] = r[CW];
        assign s_nxt[k] = (s_src[k] & ~MASK) | (WIDTH'(r[CW-1:0]) << (k * CW));
    end

    // Global stall: every stage, bubbles included, moves only when the output can advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= '0;
                bx_q[k] <= '0;
                s_q[k]  <= '0;
            end
        end else if (adv) begin
            v_q <= v_src;
            c_q <= c_nxt;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= a_src[k];
                bx_q[k] <= bx_src[k];
                s_q[k]  <= s_nxt[k];
            end
        end
    end

    assign Sum  = s_q[L];
    assign Cout = c_q[L];
    assign Ovf  = (a_q[L][WIDTH-1] == bx_q[L][WIDTH-1]) & (s_q[L][WIDTH-1] != a_q[L][WIDTH-1]);

endmodule

// File: tb/tb_rca_pipe.sv
// tb/tb_rca_pipe.sv - randomized scoreboard bench for rca_pipe
module tb_rca_pipe;
    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  A = '0;
    logic [WIDTH-1:0]  B = '0;
    logic              cin = 1'b0;
    logic              sub = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [WIDTH-1:0]  Sum;
    logic              Cout;
    logic              Ovf;

    rca_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    bit   hold_prev = 1'b0;
    res_t held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic ci, input logic sb);
        res_t r;
        int   ua, ub, sa, sbv, u, s;
        ua  = int'(a);
        ub  = int'(b);
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        if (sb) begin
            u      = ua - ub;
            s      = sa - sbv;
            r.cout = (ua >= ub);
        end else begin
            u      = ua + ub + int'(ci);
            s      = sa + sbv + int'(ci);
            r.cout = (u > 65535);
        end
        r.sum = 16'(u);
        r.ovf = (s > 32767) || (s < -32768);
        return r;
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Scoreboard: sampled after the tb drives inputs on the falling edge.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            chk("in_ready_eq_adv", in_ready, !out_valid || out_ready);
            if (hold_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", {Sum, Cout, Ovf}, held);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) chk("stale_out", out_valid, 0);
                else chk("result", {Sum, Cout, Ovf}, exp_q[0]);
            end
            hold_prev = out_valid && !out_ready;
            held      = {Sum, Cout, Ovf};
            if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (in_valid && in_ready) exp_q.push_back(model(A, B, cin, sub));
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic drive_item(input logic [15:0] a, input logic [15:0] b,
                              input logic ci, input logic sb, input bit rand_ready);
        int tries = 0;
        bit acc   = 1'b0;
        while (!acc && tries < 100) begin
            @(negedge clk);
            in_valid = 1'b1;
            A = a; B = b; cin = ci; sub = sb;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            #1;
            acc = in_ready;
            tries++;
        end
        if (!acc) chk("accept_timeout", in_ready, 1);
    endtask

    task automatic dir_test(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic ci, input logic sb,
                            input logic [15:0] esum, input logic ecout, input logic eovf);
        out_ready = 1'b1;
        drive_item(a, b, ci, sb, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #3;
            if (i < 4) chk({name, "_early"}, out_valid, 0);
            else if (i == 4) begin
                chk({name, "_valid"}, out_valid, 1);
                chk({name, "_sum"}, Sum, esum);
                chk({name, "_cout"}, Cout, ecout);
                chk({name, "_ovf"}, Ovf, eovf);
            end else chk({name, "_one_cycle"}, out_valid, 0);
        end
    endtask

    initial begin
        int n;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        chk("idle_out_valid", out_valid, 0);
        chk("idle_sum", Sum, 0);
        chk("idle_cout", Cout, 0);
        chk("idle_ovf", Ovf, 0);
        chk("idle_in_ready", in_ready, 1);

        dir_test("latency", 16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
        dir_test("ripple_all", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        dir_test("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        dir_test("neg_ovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        dir_test("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        dir_test("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        dir_test("sub_equal", 16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++)
            drive_item(rnd16(), rnd16(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                in_valid  = 1'b0;
                out_ready = 1'($urandom_range(0, 1));
            end
            drive_item(rnd16(), rnd16(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        end
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            #3;
            if (exp_q.size() == 0 && !out_valid) break;
            n++;
        end
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_valid", out_valid, 0);

        out_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            drive_item(rnd16(), rnd16(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        @(posedge clk);
        #3;
        chk("pre_reset_valid", out_valid, 1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("reset_async_valid", out_valid, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #3;
            chk("post_reset_idle", out_valid, 0);
        end
        dir_test("post_reset", 16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/rca_pipe.md
Name: rca_pipe

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor; successor to the fixed 4-bit combinational ripple-carry adder.
- Splits a WIDTH-bit add into STAGES carry-chain segments, with one register stage per segment, so wide adds meet timing.
- Adds a valid/ready stream handshake with backpressure, a subtract mode, carry-in, and signed overflow.
- Sits in datapaths that consume a stream of operand pairs, for example accumulators and address generators.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be divisible by STAGES.
- STAGES, 4, number of pipeline segments; each segment ripples CW = WIDTH/STAGES bits. Legal range 1..WIDTH.

Ports:
- clk  input  1  clock; all flops rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair on A/B/cin/sub is valid.
- in_ready  output  1  block can accept an operand pair this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: A+B+cin; 1: A-B (computed as A + ~B + 1; cin ignored).
- out_valid  output  1  result on Sum/Cout/Ovf is valid.
- out_ready  input  1  downstream accepts the result this cycle.
- Sum  output  WIDTH  result bits.
- Cout  output  1  carry out of the MSB. In sub mode, 1 means no borrow (A >= B unsigned).
- Ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset (async, rst_n=0): every stage valid bit clears to 0. out_valid=0, Sum=0, Cout=0, Ovf=0. All carry and skew registers clear to 0. in_ready follows its equation; with all stages empty it is 1.
- Advance condition: adv = !out_valid | out_ready. All stages shift together when adv=1 and hold when adv=0 (global stall, no bubbles collapsed).
- Handshake: in_ready = adv, combinational from out_ready. A transfer occurs when in_valid & in_ready. out_valid and its payload stay stable while out_valid & !out_ready.
- Stage 0 input conditioning: Bx = sub ? ~B : B; c0 = sub ? 1 : cin.
- Stage k (k = 0..STAGES-1):
  - Adds bits [k*CW +: CW] of A and Bx plus the carry registered by stage k-1 (c0 for k=0), as a CW-bit ripple chain.
  - Registers its CW sum bits, its carry-out, and its valid bit.
  - Operand slices not yet consumed travel in skew registers alongside the data.
  - Sum slices already produced travel in deskew registers, so all WIDTH sum bits emerge aligned.
- Latency: exactly STAGES cycles from input acceptance to out_valid, when not stalled.
- Throughput: one result per cycle while out_ready=1.
- Ovf = (A[MSB] == Bx[MSB]) & (Sum[MSB] != A[MSB]). The MSB operand bits are carried to the final stage for this.
- Cout is the final-stage carry-out.
- Bubble handling: an empty stage (valid=0) still shifts its data, but its contents are don't-care. Outputs are only meaningful when out_valid=1.
- Simultaneous events: output accept and input accept in the same cycle are legal and give full throughput.
- When in_valid=0 on an advancing cycle, a bubble enters stage 0.
- Reset mid-operation: all in-flight results are discarded, out_valid drops asynchronously, and no partial result is ever presented.
- STAGES=1: degenerates to a single registered WIDTH-bit adder with 1-cycle latency.
- Wrap-around: unsigned overflow is reported only via Cout. Sum is the result mod 2^WIDTH.

Test Plan (WIDTH=16, STAGES=4 unless stated):
- Reset then idle:
  - Stimulus: rst_n=0, then released, with in_valid=0.
  - Required: out_valid=0, Sum=0, Cout=0, Ovf=0, in_ready=1.
- Latency check:
  - Stimulus: A=0x1234, B=0x0FFF, cin=1, sub=0, out_ready=1, one cycle of in_valid.
  - Required: 4 cycles later, out_valid=1 for one cycle with Sum=0x2234, Cout=0, Ovf=0.
- Full carry ripple across all stages:
  - Stimulus: A=0xFFFF, B=0x0000, cin=1.
  - Required: Sum=0x0000, Cout=1, Ovf=0.
  - Stimulus: A=0x7FFF, B=0x0001, cin=0.
  - Required: Sum=0x8000, Cout=0, Ovf=1.
- Subtract mode:
  - Stimulus: A=0x0005, B=0x0007, sub=1, cin=1 (ignored).
  - Required: Sum=0xFFFE, Cout=0, Ovf=0.
  - Stimulus: A=0x8000, B=0x0001, sub=1.
  - Required: Sum=0x7FFF, Cout=1, Ovf=1.
- Backpressure:
  - Stimulus: stream 8 back-to-back random pairs, with out_ready toggled randomly.
  - Required: in_ready mirrors adv each cycle, held outputs stay stable while stalled, and every result matches the reference model in order with none dropped or duplicated.
- Reset mid-stream:
  - Stimulus: assert rst_n=0 asynchronously with 3 results in flight.
  - Required: out_valid=0 immediately. After release, no stale result appears, and the next accepted input returns after 4 cycles.
